// File: rtl/monopix.sv
// monopix: scaled pixel-matrix readout with LE/TE gray timestamps,
// token/freeze/read column-drain arbitration and a serial config register.
module monopix #(
  parameter int N_COL = 4,
  parameter int N_ROW = 8
) (
  input  logic                   clk_bx,
  input  logic                   reset,
  input  logic                   reset_bcid,
  input  logic [N_COL*N_ROW-1:0] ana_hit,
  input  logic                   inj_pulse,
  input  logic                   freeze,
  input  logic                   read,
  output logic                   token,
  output logic                   data_out,
  input  logic                   def_conf,
  input  logic                   si_conf,
  input  logic                   shift_conf,
  input  logic                   ld_conf,
  output logic                   so_conf
);
  localparam int NP = N_COL * N_ROW;
  localparam int L  = N_ROW + N_COL + NP;
  localparam int IW = (NP > 1) ? $clog2(NP) : 1;

  typedef enum logic [1:0] {IDLE, HIGH, DONE, READY} pix_t;

  logic [5:0]             bcid;
  logic [5:0]             gray;
  logic [L-1:0]           sr;
  logic [L-1:0]           act;
  logic [NP-1:0]          en;
  logic [NP-1:0]          hit;
  logic [NP-1:0]          hit_q;
  logic [N_COL-1:0]       inj_col;
  logic [N_ROW-1:0]       inj_row;
  pix_t                   st [NP];
  logic [NP-1:0][5:0]     le;
  logic [NP-1:0][5:0]     te;
  logic [26:0]            shreg;
  logic [IW-1:0]          win;
  logic [5:0]             win_col;
  logic [8:0]             win_row;
  logic                   take;

  assign gray     = bcid ^ (bcid >> 1);
  assign so_conf  = sr[L-1];
  assign data_out = shreg[26];
  assign take     = read & token;

  always_ff @(posedge clk_bx) begin
    if (reset || reset_bcid) bcid <= '0;
    else bcid <= bcid + 6'd1;
  end

  always_ff @(posedge clk_bx) begin
    if (reset) begin
      sr  <= '0;
      act <= '0;
    end else begin
      if (shift_conf) sr <= {sr[L-2:0], si_conf};
      if (ld_conf) act <= sr;
    end
  end

  always_comb begin
    en      = def_conf ? '1 : act[NP-1:0];
    inj_col = def_conf ? '0 : act[NP +: N_COL];
    inj_row = def_conf ? '0 : act[NP+N_COL +: N_ROW];
    hit     = '0;
    for (int c = 0; c < N_COL; c++)
      for (int r = 0; r < N_ROW; r++)
        hit[c*N_ROW+r] = en[c*N_ROW+r]
          & (ana_hit[c*N_ROW+r]
          | (inj_pulse & inj_col[c] & inj_row[r]));
  end

  // Scan downward so the lowest column, then lowest row, wins.
  always_comb begin
    token   = 1'b0;
    win     = '0;
    win_col = '0;
    win_row = '0;
    for (int c = N_COL-1; c >= 0; c--)
      for (int r = N_ROW-1; r >= 0; r--)
        if (st[c*N_ROW+r] == READY) begin
          token   = 1'b1;
          win     = IW'(c*N_ROW+r);
          win_col = 6'(c);
          win_row = 9'(r);
        end
  end

  always_ff @(posedge clk_bx) begin
    if (reset) begin
      hit_q <= '0;
      le    <= '0;
      te    <= '0;
      for (int i = 0; i < NP; i++) st[i] <= IDLE;
    end else begin
      hit_q <= hit;
      for (int i = 0; i < NP; i++) begin
        unique case (st[i])
          IDLE:
            if (hit[i] && !hit_q[i]) begin
              le[i] <= gray;
              st[i] <= HIGH;
            end
          HIGH:
            if (!hit[i]) begin
              te[i] <= gray;
              st[i] <= freeze ? DONE : READY;
            end
          DONE:
            if (!freeze) st[i] <= READY;
          READY: ;
        endcase
        // Readout clear and disable override any edge this cycle.
        if (!en[i] || (take && win == IW'(i)))
          st[i] <= IDLE;
      end
    end
  end

  always_ff @(posedge clk_bx) begin
    if (reset) shreg <= '0;
    else if (take)
      shreg <= {win_col, te[win], le[win], win_row};
    else shreg <= {shreg[25:0], 1'b0};
  end

endmodule

// File: tb/tb_monopix.sv
// tb_monopix: randomized + directed scoreboard bench for monopix,
// with a hit-lifecycle reference model and a serial word monitor.
module tb_monopix;
  localparam int N_COL = 4;
  localparam int N_ROW = 8;
  localparam int NP    = N_COL * N_ROW;
  localparam int L     = N_ROW + N_COL + NP;

  logic          clk_bx = 1'b0;
  logic          reset, reset_bcid, inj_pulse, freeze, read;
  logic          def_conf, si_conf, shift_conf, ld_conf;
  logic [NP-1:0] ana_hit;
  logic          token, data_out, so_conf;

  int cmp = 0;
  int bad = 0;

  always #5 clk_bx = ~clk_bx;

  monopix #(.N_COL(N_COL), .N_ROW(N_ROW)) dut (
    .clk_bx(clk_bx), .reset(reset), .reset_bcid(reset_bcid),
    .ana_hit(ana_hit), .inj_pulse(inj_pulse), .freeze(freeze),
    .read(read), .token(token), .data_out(data_out),
    .def_conf(def_conf), .si_conf(si_conf),
    .shift_conf(shift_conf), .ld_conf(ld_conf), .so_conf(so_conf)
  );

  int unsigned edges = 0;
  int unsigned clr_at = 0;
  bit          rdy_m [NP];
  bit          done_m [NP];
  logic [5:0]  le_m [NP];
  logic [5:0]  te_m [NP];
  logic [L-1:0] act_m;
  logic [L-1:0] vec;
  logic [26:0] exp_q [$];

  always @(posedge clk_bx) begin
    edges++;
    if (reset || reset_bcid) clr_at = edges;
  end

  function automatic int cur_bcid();
    return int'((edges - clr_at) % 64);
  endfunction

  function automatic logic [5:0] gray6(input int b);
    return 6'(b ^ (b >> 1));
  endfunction

  function automatic bit any_rdy();
    bit a = 0;
    for (int i = 0; i < NP; i++) a |= rdy_m[i];
    return a;
  endfunction

  function automatic bit targeted(input int i,
      input logic [NP-1:0] mask, input bit inj);
    bit en, ij;
    if (def_conf) return mask[i];
    en = act_m[i];
    ij = inj && act_m[NP + i / N_ROW]
             && act_m[NP + N_COL + i % N_ROW];
    return en && (mask[i] || ij);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
      input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_bx);
    #1;
  endtask

  task automatic wait_bcid(input int v);
    int n = 0;
    while (cur_bcid() != v && n < 70) begin
      step();
      n++;
    end
    chk("bcid align", 32'(cur_bcid()), 32'(v));
  endtask

  task automatic pulse(input logic [NP-1:0] mask, input bit inj,
      input int hi);
    bit cap [NP];
    int b = cur_bcid();
    for (int i = 0; i < NP; i++) begin
      cap[i] = 0;
      if (targeted(i, mask, inj) && !rdy_m[i] && !done_m[i]) begin
        cap[i] = 1;
        le_m[i] = gray6(b);
      end
    end
    ana_hit = mask;
    inj_pulse = inj;
    repeat (hi) step();
    chk("token while high", token, any_rdy());
    b = cur_bcid();
    for (int i = 0; i < NP; i++) if (cap[i]) te_m[i] = gray6(b);
    ana_hit = '0;
    inj_pulse = 0;
    step();
    for (int i = 0; i < NP; i++)
      if (cap[i]) begin
        if (freeze) done_m[i] = 1;
        else rdy_m[i] = 1;
      end
    chk("token after fall", token, any_rdy());
  endtask

  task automatic release_freeze();
    freeze = 0;
    step();
    for (int i = 0; i < NP; i++)
      if (done_m[i]) begin
        done_m[i] = 0;
        rdy_m[i] = 1;
      end
    chk("token after unfreeze", token, any_rdy());
  endtask

  task automatic do_read();
    int w = -1;
    for (int i = NP-1; i >= 0; i--) if (rdy_m[i]) w = i;
    if (w >= 0) begin
      exp_q.push_back({6'(w / N_ROW), te_m[w], le_m[w],
                       9'(w % N_ROW)});
      rdy_m[w] = 0;
    end
    read = 1;
    step();
    read = 0;
    chk("token after read", token, any_rdy());
  endtask

  task automatic drain();
    repeat (29) step();
  endtask

  // Serial word monitor: a load is read&token seen at a rising edge.
  bit          mon_on = 0;
  bit          mon_trail = 0;
  int          mon_cnt = 0;
  logic [26:0] mon_w = '0;

  always @(posedge clk_bx) begin
    if (reset) begin
      mon_on = 0;
      mon_trail = 0;
    end else if (read && token) begin
      mon_on = 1;
      mon_cnt = 0;
      mon_w = '0;
    end
  end

  always @(negedge clk_bx) begin
    if (mon_trail) begin
      mon_trail = 0;
      chk("data_out after word", data_out, 0);
    end
    if (mon_on) begin
      mon_w = {mon_w[25:0], data_out};
      mon_cnt++;
      if (mon_cnt == 27) begin
        mon_on = 0;
        mon_trail = 1;
        if (exp_q.size() == 0) begin
          cmp++;
          bad++;
          $display("FAIL word: got %h, none expected", mon_w);
        end else chk("word", mon_w, exp_q.pop_front());
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    logic [NP-1:0] m;
    int ones;
    bit fz;
    reset = 1; reset_bcid = 0; inj_pulse = 0; freeze = 0;
    read = 0; def_conf = 1; si_conf = 0; shift_conf = 0;
    ld_conf = 0; ana_hit = '0; act_m = '0;
    for (int i = 0; i < NP; i++) begin
      rdy_m[i] = 0;
      done_m[i] = 0;
    end
    step();
    step();
    reset = 0;
    chk("reset token", token, 0);
    chk("reset data_out", data_out, 0);
    chk("reset so_conf", so_conf, 0);

    // Pixel (0,0): LE at BCID 5, TE at BCID 13.
    wait_bcid(5);
    pulse(NP'(1), 0, 8);
    do_read();
    drain();

    // Two READY pixels drain in column-then-row order.
    m = '0;
    m[2*N_ROW+7] = 1;
    m[0*N_ROW+3] = 1;
    pulse(m, 0, 3);
    do_read();
    drain();
    do_read();
    drain();

    // Freeze across the falling edge.
    freeze = 1;
    m = '0;
    m[1*N_ROW+5] = 1;
    pulse(m, 0, 2);
    repeat (3) begin
      step();
      chk("token frozen", token, 0);
    end
    release_freeze();
    do_read();
    drain();

    // Configuration: disable (1,1), inject into (1,2).
    vec = '0;
    for (int i = 0; i < NP; i++) vec[i] = (i != 1*N_ROW+1);
    vec[NP+1] = 1;
    vec[NP+N_COL+2] = 1;
    shift_conf = 1;
    for (int k = 0; k < L; k++) begin
      si_conf = vec[L-1-k];
      step();
    end
    shift_conf = 0;
    ld_conf = 1;
    step();
    ld_conf = 0;
    act_m = vec;
    def_conf = 0;
    step();
    pulse('0, 1, 4);
    do_read();
    drain();
    m = '0;
    m[1*N_ROW+1] = 1;
    pulse(m, 0, 3);
    chk("disabled pixel token", token, 0);
    shift_conf = 1;
    for (int k = 0; k < L; k++) begin
      chk("so_conf bit", so_conf, vec[L-1-k]);
      si_conf = 1'($urandom);
      step();
    end
    shift_conf = 0;
    def_conf = 1;

    // Timestamp across the BCID wrap.
    wait_bcid(62);
    m = '0;
    m[3*N_ROW+6] = 1;
    pulse(m, 0, 3);
    do_read();
    drain();

    // Reset mid-shift with another pixel still READY.
    m = '0;
    m[4] = 1;
    m[20] = 1;
    pulse(m, 0, 2);
    do_read();
    repeat (9) step();
    reset = 1;
    step();
    reset = 0;
    chk("data_out after reset", data_out, 0);
    chk("token after reset", token, 0);
    exp_q.delete();
    act_m = '0;
    for (int i = 0; i < NP; i++) begin
      rdy_m[i] = 0;
      done_m[i] = 0;
    end
    do_read();
    ones = 0;
    repeat (28) begin
      ones += int'(data_out);
      step();
    end
    chk("read without token", 32'(ones), 0);

    // Randomized hits, freezes and drains.
    reset_bcid = 1;
    step();
    reset_bcid = 0;
    for (int it = 0; it < 40; it++) begin
      m = '0;
      repeat ($urandom_range(1, 3)) m[$urandom_range(0, NP-1)] = 1;
      fz = ($urandom_range(0, 3) == 0);
      freeze = fz;
      pulse(m, 0, $urandom_range(1, 12));
      if (fz) begin
        repeat ($urandom_range(0, 3)) step();
        release_freeze();
      end
      repeat ($urandom_range(0, 5)) step();
      if ($urandom_range(0, 2) == 0 || it == 39)
        while (any_rdy()) begin
          do_read();
          drain();
        end
    end
    drain();
    chk("scoreboard empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
